response_checker: RTL and testbench
===================================

// Module: response_checker
// PURPOSE
//  Hardware end of the exhaustive stimulus flow: consumes (vector, response) pairs from a
//  stimulus driver, compares each response to a compiled-in truth table, tracks which input
//  vectors were applied, and reports a pass/fail verdict. Sits beside the circuit under test
//  and removes manual $monitor inspection; also flags missing or duplicated vectors.
// PARAMETERS
//  N_IN      5    input vector width; table depth = 2**N_IN
//  N_OUT     2    response width ({OutF,OutG} for the default circuit)
//  NUM_VEC   32   accepted vectors per run before Done (1..255)
//  EXP_TABLE 0    N_OUT*2**N_IN bits; expected response for vector v = EXP_TABLE[v*N_OUT +: N_OUT]
//  ERR_W     8    width of ErrCount (saturating)
// PORTS
//  Clock     in   1          rising-edge clock
//  Reset     in   1          asynchronous, active-high reset
//  Start     in   1          begin a run (pulse); honoured in IDLE and DONE only
//  InValid   in   1          InVec/InResp valid this cycle
//  InVec     in   N_IN       applied input vector {InA..InE}, InA = MSB
//  InResp    in   N_OUT      observed response, MSB = OutF
//  Busy      out  1          high in RUN
//  Done      out  1          high in DONE
//  Pass      out  1          valid when Done: ErrCount==0 and MissCount==0
//  ErrCount  out  ERR_W      mismatching responses this run, saturates at all-ones
//  VecCount  out  8          vectors accepted this run
//  MissCount out  N_IN+1     table entries never applied this run (valid when Done)
// BEHAVIOUR
//  - Reset (any time, incl. mid-run): state IDLE; Busy, Done, Pass, ErrCount, VecCount,
//    MissCount = 0; coverage bitmap (2**N_IN bits) cleared.
//  - FSM IDLE -> RUN on Start; RUN -> DONE after NUM_VEC-th accept; DONE -> RUN on Start.
//    Entering RUN clears counters, bitmap, Pass, MissCount in the same edge.
//  - Accept = InValid high in RUN, sampled at rising Clock. All outputs registered; effects
//    of an accept are visible after that same edge (latency 1 cycle, no backpressure).
//  - Per accept: VecCount+1; bitmap[InVec]=1; if InResp != expected, ErrCount+1 unless all-ones.
//  - On NUM_VEC-th accept: state DONE, Busy=0, Done=1, MissCount = zeros in bitmap
//    including the final accept, Pass set from final ErrCount/MissCount in the same edge.
//  - InValid in IDLE/DONE ignored. Start in RUN ignored. Start and InValid same cycle in
//    IDLE/DONE: Start wins, vector dropped. Duplicate vectors are checked normally and
//    counted toward NUM_VEC; they surface only through MissCount.
//  - X/Z on InResp during an accept counts as a mismatch (compare with !==).
// CONFIGURATION
//  FIRST_FAIL_EN defined: adds outputs FailValid(1), FailVec(N_IN), FailResp(N_OUT);
//    on first mismatch of a run, capture InVec/InResp, set FailValid; hold until next
//    Start or Reset (both clear all three to 0). Later mismatches do not overwrite.
//  Undefined: ports and capture registers absent; all other behaviour identical.
// TESTING
//  T1 Reset mid-run after 10 accepts -> all outputs 0 same cycle, IDLE; Start restarts clean.
//  T2 Start, vectors 0..31 with correct responses -> Done after 32nd, VecCount=32,
//     ErrCount=0, MissCount=0, Pass=1.
//  T3 As T2, vector 5 response inverted -> ErrCount=1, Pass=0; with FIRST_FAIL_EN
//     FailValid=1, FailVec=5, FailResp=~expected.
//  T4 As T2, vector 6 replaced by repeat of 14 (correct response) -> ErrCount=0,
//     MissCount=1, Pass=0.
//  T5 ERR_W=4, all 32 responses wrong -> ErrCount=15, Pass=0.
//  T6 InValid pulses in IDLE and DONE, Start mid-RUN -> no counter change, run completes
//     at 32nd accept.

Source files
------------

// File: rtl/response_checker.sv
// ----------------------------------------------------------------------------
// response_checker
//   Hardware end of an exhaustive stimulus flow. It consumes (vector, response)
//   pairs from a stimulus driver and compares each response to a compiled-in
//   truth table. It also records which input vectors were applied. When the
//   run ends it reports a pass/fail verdict, so nobody has to inspect a
//   waveform or a $monitor log by hand. Missing or duplicated vectors show up
//   through MissCount.
//
// Parameters
//   N_IN      input vector width; truth-table depth is 2**N_IN
//   N_OUT     response width
//   NUM_VEC   accepted vectors per run before Done (1..255)
//   EXP_TABLE expected response for vector v is EXP_TABLE[v*N_OUT +: N_OUT]
//   ERR_W     width of ErrCount (saturating)
//
// Ports
//   Clock      rising-edge clock
//   Reset      asynchronous, active-high reset
//   Start      begin a run (pulse); honoured in IDLE and DONE only
//   InValid    InVec/InResp valid this cycle (accepted only in RUN)
//   InVec      applied input vector, MSB first
//   InResp     observed response
//   Busy       high while a run is in progress
//   Done       high once NUM_VEC vectors have been accepted
//   Pass       valid with Done: no mismatches and every vector applied
//   ErrCount   mismatching responses this run, saturates at all-ones
//   VecCount   vectors accepted this run
//   MissCount  truth-table entries never applied this run (valid with Done)
//
// Optional feature (macro FIRST_FAIL_EN)
//   Adds FailValid/FailVec/FailResp. These capture the first mismatching
//   pair of a run and hold it until the next Start or Reset.
// ----------------------------------------------------------------------------
module response_checker #(
    parameter int N_IN    = 5,
    parameter int N_OUT   = 2,
    parameter int NUM_VEC = 32,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TABLE = '0,
    parameter int ERR_W   = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               InValid,
    input  logic [N_IN-1:0]    InVec,
    input  logic [N_OUT-1:0]   InResp,
    output logic               Busy,
    output logic               Done,
    output logic               Pass,
    output logic [ERR_W-1:0]   ErrCount,
    output logic [7:0]         VecCount,
    output logic [N_IN:0]      MissCount
`ifdef FIRST_FAIL_EN
    ,
    output logic               FailValid,
    output logic [N_IN-1:0]    FailVec,
    output logic [N_OUT-1:0]   FailResp
`endif
);

    localparam int DEPTH = 2**N_IN;

    localparam logic [ERR_W-1:0] ERR_ONE  = 1;
    localparam logic [N_IN:0]    MISS_ONE = 1;
    localparam logic [7:0]       VEC_LAST = 8'(NUM_VEC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               pass_q,      pass_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [7:0]         vec_count_q, vec_count_d;
    logic [N_IN:0]      miss_count_q, miss_count_d;
    logic [DEPTH-1:0]   bitmap_q,    bitmap_d;
`ifdef FIRST_FAIL_EN
    logic               fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]    fail_vec_q,   fail_vec_d;
    logic [N_OUT-1:0]   fail_resp_q,  fail_resp_d;
`endif

    // The truth table is unpacked into one entry per vector. The lookup is then
    // a plain array index on InVec instead of a computed part-select.
    logic [N_OUT-1:0] exp_mem [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_exp
        assign exp_mem[gi] = EXP_TABLE[gi*N_OUT +: N_OUT];
    end

    logic [N_OUT-1:0] exp_resp;
    logic             mismatch;
    logic [N_IN:0]    miss_tmp;

    assign exp_resp = exp_mem[InVec];
    // The case-inequality operator makes an X or Z on InResp count as a mismatch.
    assign mismatch = (InResp !== exp_resp);

    always_comb begin
        // NOTE: every signal written here gets its hold value first. Otherwise a
        // path that does not assign it would infer a latch.
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        vec_count_d  = vec_count_q;
        miss_count_d = miss_count_q;
        bitmap_d     = bitmap_q;
        miss_tmp     = '0;
`ifdef FIRST_FAIL_EN
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_resp_d  = fail_resp_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // Start takes priority; a vector presented in the same cycle is dropped.
                if (Start) begin
                    state_d      = S_RUN;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = '0;
                    vec_count_d  = '0;
                    miss_count_d = '0;
                    bitmap_d     = '0;
`ifdef FIRST_FAIL_EN
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    fail_resp_d  = '0;
`endif
                end
            end

            S_RUN: begin
                if (InValid) begin
                    vec_count_d     = vec_count_q + 8'd1;
                    bitmap_d[InVec] = 1'b1;
                    if (mismatch && (err_count_q != '1))
                        err_count_d = err_count_q + ERR_ONE;
`ifdef FIRST_FAIL_EN
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = InVec;
                        fail_resp_d  = InResp;
                    end
`endif
                    // The last accept closes the run. The verdict includes this
                    // accept's bitmap entry and error count.
                    if (vec_count_d == VEC_LAST) begin
                        for (int i = 0; i < DEPTH; i++)
                            if (!bitmap_d[i])
                                miss_tmp = miss_tmp + MISS_ONE;
                        state_d      = S_DONE;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        miss_count_d = miss_tmp;
                        pass_d       = (err_count_d == '0) && (miss_tmp == '0);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // NOTE: the coverage bitmap is a register array, but it is reset like any
    // other state. A run started after Reset must see no stale coverage.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            vec_count_q  <= '0;
            miss_count_q <= '0;
            bitmap_q     <= '0;
`ifdef FIRST_FAIL_EN
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_resp_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // pre-edge values computed above.
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            vec_count_q  <= vec_count_d;
            miss_count_q <= miss_count_d;
            bitmap_q     <= bitmap_d;
`ifdef FIRST_FAIL_EN
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_resp_q  <= fail_resp_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign ErrCount  = err_count_q;
    assign VecCount  = vec_count_q;
    assign MissCount = miss_count_q;
`ifdef FIRST_FAIL_EN
    assign FailValid = fail_valid_q;
    assign FailVec   = fail_vec_q;
    assign FailResp  = fail_resp_q;
`endif

endmodule

// File: tb/tb_response_checker.sv
// ----------------------------------------------------------------------------
// tb_response_checker
//   Directed bench for response_checker. The reference circuit is
//   OutF = parity(v) and OutG = (v[4] & v[0]) | v[2]. Its truth table is built
//   by a bench function and passed in as EXP_TABLE.
//   Instance dut uses ERR_W=8. Instance dut4 uses ERR_W=4 to show counter
//   saturation. Both instances see the same stimulus.
//   Inputs are driven 1 ns after the rising edge and outputs are checked at
//   that same point.
// ----------------------------------------------------------------------------
module tb_response_checker;

    function automatic logic [1:0] ref_resp(input logic [4:0] v);
        return {^v, (v[4] & v[0]) | v[2]};
    endfunction

    function automatic logic [63:0] build_table();
        logic [63:0] t;
        t = '0;
        for (int v = 0; v < 32; v++)
            t[v*2 +: 2] = ref_resp(5'(v));
        return t;
    endfunction

    localparam logic [63:0] TABLE = build_table();

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [4:0] in_vec;
    logic [1:0] in_resp;

    logic       busy, done, pass;
    logic [7:0] err_count, vec_count;
    logic [5:0] miss_count;
    logic       busy4, done4, pass4;
    logic [3:0] err_count4;
    logic [7:0] vec_count4;
    logic [5:0] miss_count4;
`ifdef FIRST_FAIL_EN
    logic       fail_valid, fail_valid4;
    logic [4:0] fail_vec, fail_vec4;
    logic [1:0] fail_resp, fail_resp4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    response_checker #(.N_IN(5), .N_OUT(2), .NUM_VEC(32), .EXP_TABLE(TABLE), .ERR_W(8)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .InValid(in_valid),
        .InVec(in_vec), .InResp(in_resp),
        .Busy(busy), .Done(done), .Pass(pass),
        .ErrCount(err_count), .VecCount(vec_count), .MissCount(miss_count)
`ifdef FIRST_FAIL_EN
        , .FailValid(fail_valid), .FailVec(fail_vec), .FailResp(fail_resp)
`endif
    );

    response_checker #(.N_IN(5), .N_OUT(2), .NUM_VEC(32), .EXP_TABLE(TABLE), .ERR_W(4)) dut4 (
        .Clock(clk), .Reset(rst), .Start(start), .InValid(in_valid),
        .InVec(in_vec), .InResp(in_resp),
        .Busy(busy4), .Done(done4), .Pass(pass4),
        .ErrCount(err_count4), .VecCount(vec_count4), .MissCount(miss_count4)
`ifdef FIRST_FAIL_EN
        , .FailValid(fail_valid4), .FailVec(fail_vec4), .FailResp(fail_resp4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] v, input logic [1:0] r);
        in_valid = 1'b1;
        in_vec   = v;
        in_resp  = r;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic p,
                                input logic [7:0] e, input logic [7:0] n, input logic [5:0] m);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".pass"}, 32'(pass), 32'(p));
        check({tag, ".err"},  32'(err_count), 32'(e));
        check({tag, ".vec"},  32'(vec_count), 32'(n));
        check({tag, ".miss"}, 32'(miss_count), 32'(m));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_resp = '0;
        #12;
        check_status("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 6'd0);
        rst = 1'b0;
        step();

        // InValid while IDLE is ignored.
        send(5'd7, ref_resp(5'd7));
        check_status("idle_valid", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 6'd0);

        // T1: reset mid-run after 10 accepts (vector 3 wrong).
        pulse_start();
        check("t1.busy_after_start", 32'(busy), 32'd1);
        for (int v = 0; v < 10; v++)
            send(5'(v), (v == 3) ? ~ref_resp(5'(v)) : ref_resp(5'(v)));
        check("t1.vec10", 32'(vec_count), 32'd10);
        check("t1.err1", 32'(err_count), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_status("t1.async_rst", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 6'd0);
        #2 rst = 1'b0;

        // T2: clean full run after the reset.
        pulse_start();
        for (int v = 0; v < 31; v++)
            send(5'(v), ref_resp(5'(v)));
        check_status("t2.pre_last", 1'b1, 1'b0, 1'b0, 8'd0, 8'd31, 6'd0);
        send(5'd31, ref_resp(5'd31));
        check_status("t2.done", 1'b0, 1'b1, 1'b1, 8'd0, 8'd32, 6'd0);

        // T3: vector 5 response inverted.
        pulse_start();
        check_status("t3.start_clears", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 6'd0);
        for (int v = 0; v < 32; v++)
            send(5'(v), (v == 5) ? ~ref_resp(5'(v)) : ref_resp(5'(v)));
        check_status("t3.done", 1'b0, 1'b1, 1'b0, 8'd1, 8'd32, 6'd0);
`ifdef FIRST_FAIL_EN
        check("t3.fail_valid", 32'(fail_valid), 32'd1);
        check("t3.fail_vec", 32'(fail_vec), 32'd5);
        check("t3.fail_resp", 32'(fail_resp), 32'(~ref_resp(5'd5)));
`endif

        // T4: vector 6 replaced by a repeat of 14.
        pulse_start();
`ifdef FIRST_FAIL_EN
        check("t4.fail_cleared", 32'(fail_valid), 32'd0);
`endif
        for (int v = 0; v < 32; v++)
            send((v == 6) ? 5'd14 : 5'(v), ref_resp((v == 6) ? 5'd14 : 5'(v)));
        check_status("t4.done", 1'b0, 1'b1, 1'b0, 8'd0, 8'd32, 6'd1);

        // T5: every response wrong; the 4-bit counter saturates.
        pulse_start();
        for (int v = 0; v < 32; v++)
            send(5'(v), ~ref_resp(5'(v)));
        check_status("t5.done", 1'b0, 1'b1, 1'b0, 8'd32, 8'd32, 6'd0);
        check("t5.err4_sat", 32'(err_count4), 32'd15);
        check("t5.pass4", 32'(pass4), 32'd0);
        check("t5.done4", 32'(done4), 32'd1);

        // T6: InValid in DONE is ignored.
        send(5'd1, ref_resp(5'd1));
        send(5'd2, 2'b00);
        check_status("t6.done_valid", 1'b0, 1'b1, 1'b0, 8'd32, 8'd32, 6'd0);
        // Start and InValid together in DONE: Start wins and the vector is dropped.
        start = 1'b1;
        send(5'd0, ref_resp(5'd0));
        start = 1'b0;
        check_status("t6.start_wins", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 6'd0);
        for (int v = 0; v < 16; v++)
            send(5'(v), ref_resp(5'(v)));
        // A Start pulse alone in RUN has no effect.
        pulse_start();
        check_status("t6.start_in_run", 1'b1, 1'b0, 1'b0, 8'd0, 8'd16, 6'd0);
        // Start together with InValid in RUN: the vector is still accepted.
        start = 1'b1;
        send(5'd16, ref_resp(5'd16));
        start = 1'b0;
        check("t6.start_valid_run", 32'(vec_count), 32'd17);
        for (int v = 17; v < 32; v++)
            send(5'(v), ref_resp(5'(v)));
        check_status("t6.done", 1'b0, 1'b1, 1'b1, 8'd0, 8'd32, 6'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
